// File: rtl/sd_acq_sample_ctrl_if.sv
// Bundle of the acquisition-window, configuration and sample-handshake signals
// for sd_acq_sample_ctrl. ovr_cnt exists only when SD_ACQ_OVR_CNT_EN is defined.
interface sd_acq_sample_ctrl_if #(
  parameter int CW = 22,
  parameter int IW = 16
);
  logic          s_acq;
  logic [CW-1:0] count;
  logic [CW-1:0] start_dly;
  logic [IW-1:0] samp_div;
  logic [CW-1:0] acq_len;
  logic          samp_ack;
  logic          samp_req;
  logic [IW-1:0] samp_idx;
  logic          acq_done;
  logic          busy;
  logic          ovr;
`ifdef SD_ACQ_OVR_CNT_EN
  logic [7:0]    ovr_cnt;
`endif
  logic [1:0]    state;

  // Handshake: samp_req (valid) stays high until a cycle where it is sampled
  // together with samp_ack (ready); ack may be tied high for one-cycle pulses.
  modport master (
    output s_acq, count, start_dly, samp_div, acq_len, samp_ack,
    input  samp_req, samp_idx, acq_done, busy, ovr, state
`ifdef SD_ACQ_OVR_CNT_EN
    , input ovr_cnt
`endif
  );

  modport slave (
    input  s_acq, count, start_dly, samp_div, acq_len, samp_ack,
    output samp_req, samp_idx, acq_done, busy, ovr, state
`ifdef SD_ACQ_OVR_CNT_EN
    , output ovr_cnt
`endif
  );
endinterface

// File: rtl/sd_acq_sample_ctrl.sv
// Paces ADC sample requests off the acquisition timer count (start delay,
// interval, window length). SD_ACQ_OVR_CNT_EN adds a saturating overrun counter.
module sd_acq_sample_ctrl #(
  parameter int CW = 22,
  parameter int IW = 16
) (
  input logic                 dds,
  input logic                 rst,
  sd_acq_sample_ctrl_if.slave acq
);
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DELAY = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t        state_q;
  logic          s_acq_q;
  logic [IW-1:0] div_q;
  logic [CW-1:0] len_q;
  logic [CW:0]   next_due;
  logic          req_q;
  logic [IW-1:0] idx_q;
  logic          done_q;
  logic          busy_q;
  logic          ovr_q;
`ifdef SD_ACQ_OVR_CNT_EN
  logic [7:0]    ovr_cnt_q;
`endif

  logic rise;
  logic due_hit;
  logic len_hit;

  assign rise    = acq.s_acq && !s_acq_q;
  // A carry in next_due means the schedule ran past the top of count.
  assign due_hit = !next_due[CW] && (acq.count >= next_due[CW-1:0]);
  assign len_hit = acq.count >= len_q;

  always_ff @(posedge dds) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      s_acq_q   <= 1'b0;
      div_q     <= '0;
      len_q     <= '0;
      next_due  <= '0;
      req_q     <= 1'b0;
      idx_q     <= '0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      ovr_q     <= 1'b0;
`ifdef SD_ACQ_OVR_CNT_EN
      ovr_cnt_q <= '0;
`endif
    end else begin
      s_acq_q <= acq.s_acq;
      done_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (rise) begin
            div_q     <= (acq.samp_div == '0) ? IW'(1) : acq.samp_div;
            len_q     <= acq.acq_len;
            next_due  <= {1'b0, acq.start_dly};
            idx_q     <= '0;
            ovr_q     <= 1'b0;
`ifdef SD_ACQ_OVR_CNT_EN
            ovr_cnt_q <= '0;
`endif
            busy_q    <= 1'b1;
            state_q   <= ST_DELAY;
          end
        end
        ST_DELAY, ST_RUN: begin
          // Termination wins over a coincident issue; this also covers
          // start_dly >= acq_len, which ends the window from DELAY.
          if (!acq.s_acq || len_hit) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            req_q   <= 1'b0;
            state_q <= ST_DONE;
          end else if (due_hit) begin
            req_q    <= 1'b1;
            next_due <= next_due + {{(CW+1-IW){1'b0}}, div_q};
            if (state_q == ST_RUN) idx_q <= idx_q + IW'(1);
            if (req_q && !acq.samp_ack) begin
              ovr_q <= 1'b1;
`ifdef SD_ACQ_OVR_CNT_EN
              if (ovr_cnt_q != 8'hFF) ovr_cnt_q <= ovr_cnt_q + 8'd1;
`endif
            end
            state_q <= ST_RUN;
          end else if (req_q && acq.samp_ack) begin
            req_q <= 1'b0;
          end
        end
        ST_DONE: begin
          if (!acq.s_acq) state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign acq.samp_req = req_q;
  assign acq.samp_idx = idx_q;
  assign acq.acq_done = done_q;
  assign acq.busy     = busy_q;
  assign acq.ovr      = ovr_q;
  assign acq.state    = state_q;
`ifdef SD_ACQ_OVR_CNT_EN
  assign acq.ovr_cnt  = ovr_cnt_q;
`endif
endmodule
